// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product sampling and block-result handshake bundle.
interface product_accumulator_if #(
  parameter int unsigned ACC_W = 24
);
  logic             done_sig;
  logic [15:0]      product;
  logic             clear;
  logic             result_ack;
  logic             result_valid;
  logic [ACC_W-1:0] result;
  logic [7:0]       sample_cnt;
  logic             overflow;
  logic             lost;

  modport master (
    output done_sig, product, clear, result_ack,
    input  result_valid, result, sample_cnt, overflow, lost
  );

  modport slave (
    input  done_sig, product, clear, result_ack,
    output result_valid, result, sample_cnt, overflow, lost
  );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums fixed-length blocks of multiplier products into a held result.
module product_accumulator #(
  parameter int unsigned BLOCK_LEN = 4,
  parameter int unsigned ACC_W     = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);
  typedef enum logic {COLLECT, LAST} state_e;

  localparam logic [7:0] LAST_CNT = 8'(BLOCK_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             overflow_q, overflow_d;
  logic             lost_q, lost_d;

  logic [ACC_W:0]   sum;
  logic             block_done;
  logic             result_free;

  assign sum         = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, bus.product};
  assign result_free = !result_valid_q || bus.result_ack;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overflow_d     = overflow_q;
    lost_d         = lost_q;
    block_done     = 1'b0;

    // Clear wins over a coinciding product; that product is simply dropped.
    if (bus.clear) begin
      acc_d      = '0;
      cnt_d      = '0;
      overflow_d = 1'b0;
      lost_d     = 1'b0;
    end else if (bus.done_sig) begin
      if (sum[ACC_W]) begin
        overflow_d = 1'b1;
      end
      if (state_q == LAST) begin
        acc_d      = '0;
        cnt_d      = '0;
        block_done = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
        cnt_d = cnt_q + 8'd1;
      end
    end

    // An ack in the completing cycle frees the register for the new sum.
    if (block_done) begin
      if (result_free) begin
        result_d       = sum[ACC_W-1:0];
        result_valid_d = 1'b1;
      end else begin
        lost_d = 1'b1;
      end
    end else if (result_valid_q && bus.result_ack) begin
      result_valid_d = 1'b0;
    end

    state_d = (cnt_d == LAST_CNT) ? LAST : COLLECT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= COLLECT;
      acc_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      lost_q         <= lost_d;
    end
  end

  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.sample_cnt   = cnt_q;
  assign bus.overflow     = overflow_q;
  assign bus.lost         = lost_q;
endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream consumer of the FIFO-fed multiplier stage. It samples each 16-bit product on the multiplier's one-cycle done pulse and sums a fixed-length block of products, a dot-product style reduction. Each completed block sum is presented on a held, valid/ack output register. Accumulation of the next block continues while a finished result waits for collection.

## Interface
Parameters:
- BLOCK_LEN, default 4: products per block; legal range 2..255.
- ACC_W, default 24: accumulator and result width; legal range 16..32.

Ports:
- clk, input, 1: single clock, all logic on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- done_sig, input, 1: one-cycle pulse; `product` is valid in that cycle. May be high on consecutive cycles.
- product, input, 16: unsigned product, zero-extended to ACC_W.
- clear, input, 1: synchronous abort of the partial block; also clears the sticky flags.
- result_valid, output, 1: a block sum is held on `result`.
- result, output, ACC_W: completed block sum.
- result_ack, input, 1: consumer takes `result`; honoured only while result_valid=1.
- sample_cnt, output, 8: products accumulated in the current partial block.
- overflow, output, 1: sticky; some addition carried out of ACC_W bits.
- lost, output, 1: sticky; a completed block was dropped because the result register was occupied.

## Operation
- Registers: acc[ACC_W-1:0], cnt[7:0] (drives sample_cnt), result register, result_valid, overflow, lost.
- Sum: sum = {1'b0,acc} + zero-extended product, computed at ACC_W+1 bits. sum[ACC_W] is the carry. Arithmetic wraps modulo 2^ACC_W.
- Two-state FSM on cnt:
  - COLLECT: cnt < BLOCK_LEN-1.
  - LAST: cnt == BLOCK_LEN-1.
- COLLECT with done_sig:
  - acc <= sum[ACC_W-1:0]
  - cnt <= cnt+1
- LAST with done_sig (block complete):
  - acc <= 0, cnt <= 0.
  - If the result register is free, it loads sum[ACC_W-1:0] and result_valid <= 1.
  - Otherwise the new sum is discarded, lost <= 1, and the old result is untouched.
- Result register is free when result_valid=0, or when result_valid=1 and result_ack=1 in the same cycle. The pass-through case loads the new result and keeps result_valid high.
- Ack:
  - result_ack while result_valid=1 with no block completing clears result_valid next cycle.
  - result_ack while result_valid=0 is ignored.
  - `result` holds its last value after ack.
- Carry: any cycle with done_sig and carry=1 sets overflow <= 1.
- Clear: has priority over done_sig in the same cycle.
  - acc <= 0, cnt <= 0, overflow <= 0, lost <= 0.
  - The product in that cycle is discarded.
  - result, result_valid and ack handling are unaffected.
- Reset (rst_n=0 at an edge), including mid-block or with a result pending:
  - acc=0, cnt=0, result=0, result_valid=0, overflow=0, lost=0.
  - All inputs are ignored.

## Timing
- Reset value of every output: result_valid=0, result=0, sample_cnt=0, overflow=0, lost=0.
- Throughput: one product per cycle. No stall output exists; upstream is never back-pressured.
- Latency: result_valid rises on the edge that samples the last done_sig of a block. It is visible in the following cycle.
- sample_cnt updates on the edge after each done_sig.
- result_valid stays high until the edge on which result_ack=1 is sampled.
- Consumer may hold result_ack high continuously; each block then produces a one-cycle result_valid pulse.
- Sticky flags change only at the accumulation edge, clear, or reset.

## Test plan
- Basic block (BLOCK_LEN=4, ACC_W=24): products 0x0003, 0x0005, 0x0007, 0x0009 on four spaced done_sig pulses -> result=0x000018, result_valid=1 one cycle after the 4th pulse; sample_cnt steps 1,2,3,0; ack -> result_valid=0 next cycle.
- Back-to-back with pending result: 8 consecutive done_sig cycles of 0x0100, no ack -> first result 0x000400 held, lost=1 after the 8th sample, result stays 0x000400. Repeat with result_ack held high -> two results of 0x000400, lost=0.
- Ack/load collision: result 0x000018 pending, ack asserted on the same cycle the next block's last product arrives (block sum 0x000020) -> result=0x000020, result_valid stays 1, lost=0.
- Overflow (ACC_W=17): four products of 0xFFFF -> result=0x1FFFC, overflow=1 at the 3rd product; clear -> overflow=0.
- Clear mid-block: two products 0x0010, then clear coinciding with a done_sig of 0x0020, then four products of 0x0001 -> result=0x000004, sample_cnt=0 after clear.
- Reset mid-block with result pending: rst_n low one cycle -> all outputs at reset values next cycle; the following four products of 0x0002 give result=0x000008.
